// File: rtl/data_path_pkg.sv
// Shared widths and types for the single-bus datapath.
// Every other file of this block imports this package.
package data_path_pkg;
    localparam int DATA_W = 32;
    localparam int Z_W    = 64;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/data_path_if.sv
// Control, memory-data and observation signals of the datapath, grouped as one bundle.
// master drives the controls; slave is the datapath itself.
interface data_path_if;
    import data_path_pkg::*;

    logic  PCout, Zlowout, MDRout, R2out, R3out;
    logic  MARin, Zin, PCin, MDRin, Yin, IRin, R1in, R2in, R3in;
    logic  IncPC, AND, Read;
    word_t Mdatain;
    word_t BusMuxOut;
    word_t R1_q, R2_q, R3_q, PC_q, MAR_q, IR_q, MDR_q, Y_q, ZLo_q, ZHi_q;

    modport master (
        output PCout, Zlowout, MDRout, R2out, R3out,
        output MARin, Zin, PCin, MDRin, Yin, IRin, R1in, R2in, R3in,
        output IncPC, AND, Read, Mdatain,
        input  BusMuxOut,
        input  R1_q, R2_q, R3_q, PC_q, MAR_q, IR_q, MDR_q, Y_q, ZLo_q, ZHi_q
    );

    modport slave (
        input  PCout, Zlowout, MDRout, R2out, R3out,
        input  MARin, Zin, PCin, MDRin, Yin, IRin, R1in, R2in, R3in,
        input  IncPC, AND, Read, Mdatain,
        output BusMuxOut,
        output R1_q, R2_q, R3_q, PC_q, MAR_q, IR_q, MDR_q, Y_q, ZLo_q, ZHi_q
    );
endinterface

// File: rtl/data_path_register32.sv
// 32-bit D register with load enable; Clear wins over the enable.
module register32
    import data_path_pkg::*;
(
    input  logic  Clock,
    input  logic  Clear,
    input  logic  en,
    input  word_t d,
    output word_t q
);
    word_t q_reg;

    always_ff @(posedge Clock) begin
        if (Clear) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/data_path.sv
// Single-bus datapath: priority bus mux, MDR input mux, Y/bus ALU and the register file.
// All registers are register32 instances; Z is two of them (low = ALU result, high = zero).
module data_path
    import data_path_pkg::*;
(
    input  logic Clock,
    input  logic Clear,
    data_path_if.slave dp
);
    localparam int N_BUS_REGS = 7;

    word_t bus_mux;
    word_t mdr_d;
    word_t alu_result;

    // Index order: R1, R2, R3, PC, MAR, IR, Y -- all load straight from the bus.
    logic [N_BUS_REGS-1:0] bus_load_en;
    word_t                 bus_reg_q [N_BUS_REGS];

    assign bus_load_en = {dp.Yin, dp.IRin, dp.MARin, dp.PCin, dp.R3in, dp.R2in, dp.R1in};

    // Sources are register outputs only, so same-register out+in loads the pre-edge value.
    always_comb begin
        bus_mux = '0;
        if (dp.Zlowout) begin
            bus_mux = dp.ZLo_q;
        end else if (dp.MDRout) begin
            bus_mux = dp.MDR_q;
        end else if (dp.PCout) begin
            bus_mux = dp.PC_q;
        end else if (dp.R2out) begin
            bus_mux = dp.R2_q;
        end else if (dp.R3out) begin
            bus_mux = dp.R3_q;
        end
    end

    always_comb begin
        alu_result = dp.Y_q + bus_mux;
        if (dp.AND) begin
            alu_result = dp.Y_q & bus_mux;
        end else if (dp.IncPC) begin
            alu_result = bus_mux + word_t'(1);
        end
    end

    assign mdr_d = dp.Read ? dp.Mdatain : bus_mux;

    generate
        for (genvar gi = 0; gi < N_BUS_REGS; gi++) begin : g_bus_regs
            register32 u_reg (
                .Clock (Clock),
                .Clear (Clear),
                .en    (bus_load_en[gi]),
                .d     (bus_mux),
                .q     (bus_reg_q[gi])
            );
        end
    endgenerate

    register32 u_mdr (
        .Clock (Clock),
        .Clear (Clear),
        .en    (dp.MDRin),
        .d     (mdr_d),
        .q     (dp.MDR_q)
    );

    register32 u_zlo (
        .Clock (Clock),
        .Clear (Clear),
        .en    (dp.Zin),
        .d     (alu_result),
        .q     (dp.ZLo_q)
    );

    register32 u_zhi (
        .Clock (Clock),
        .Clear (Clear),
        .en    (dp.Zin),
        .d     ({(Z_W-DATA_W){1'b0}}),
        .q     (dp.ZHi_q)
    );

    assign dp.BusMuxOut = bus_mux;
    assign dp.R1_q      = bus_reg_q[0];
    assign dp.R2_q      = bus_reg_q[1];
    assign dp.R3_q      = bus_reg_q[2];
    assign dp.PC_q      = bus_reg_q[3];
    assign dp.MAR_q     = bus_reg_q[4];
    assign dp.IR_q      = bus_reg_q[5];
    assign dp.Y_q       = bus_reg_q[6];
endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: a vector table of one-cycle control words plus
// hand-written reset and mid-sequence Clear checks.
module tb_data_path;
    import data_path_pkg::*;

    logic Clock;
    logic Clear;

    data_path_if dp_if ();

    data_path dut (
        .Clock (Clock),
        .Clear (Clear),
        .dp    (dp_if.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [16:0] C_PCOUT   = 17'h00001;
    localparam logic [16:0] C_ZLOWOUT = 17'h00002;
    localparam logic [16:0] C_MDROUT  = 17'h00004;
    localparam logic [16:0] C_R2OUT   = 17'h00008;
    localparam logic [16:0] C_R3OUT   = 17'h00010;
    localparam logic [16:0] C_MARIN   = 17'h00020;
    localparam logic [16:0] C_ZIN     = 17'h00040;
    localparam logic [16:0] C_PCIN    = 17'h00080;
    localparam logic [16:0] C_MDRIN   = 17'h00100;
    localparam logic [16:0] C_YIN     = 17'h00200;
    localparam logic [16:0] C_IRIN    = 17'h00400;
    localparam logic [16:0] C_R1IN    = 17'h00800;
    localparam logic [16:0] C_R2IN    = 17'h01000;
    localparam logic [16:0] C_R3IN    = 17'h02000;
    localparam logic [16:0] C_INCPC   = 17'h04000;
    localparam logic [16:0] C_AND     = 17'h08000;
    localparam logic [16:0] C_READ    = 17'h10000;

    localparam int R_NONE = -1;
    localparam int R_R1 = 0, R_R2 = 1, R_R3 = 2, R_PC = 3, R_MAR = 4;
    localparam int R_IR = 5, R_MDR = 6, R_Y = 7, R_ZLO = 8, R_ZHI = 9;

    typedef struct {
        logic [16:0] ctrl;
        logic [31:0] md;
        bit          chk_bus;
        logic [31:0] exp_bus;
        int          sel_a;
        logic [31:0] exp_a;
        int          sel_b;
        logic [31:0] exp_b;
    } vec_t;

    localparam int N_VEC = 25;
    vec_t vecs [N_VEC];

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] get_reg(input int s);
        case (s)
            R_R1:    return dp_if.R1_q;
            R_R2:    return dp_if.R2_q;
            R_R3:    return dp_if.R3_q;
            R_PC:    return dp_if.PC_q;
            R_MAR:   return dp_if.MAR_q;
            R_IR:    return dp_if.IR_q;
            R_MDR:   return dp_if.MDR_q;
            R_Y:     return dp_if.Y_q;
            R_ZLO:   return dp_if.ZLo_q;
            default: return dp_if.ZHi_q;
        endcase
    endfunction

    function automatic string reg_name(input int s);
        case (s)
            R_R1:    return "R1";
            R_R2:    return "R2";
            R_R3:    return "R3";
            R_PC:    return "PC";
            R_MAR:   return "MAR";
            R_IR:    return "IR";
            R_MDR:   return "MDR";
            R_Y:     return "Y";
            R_ZLO:   return "ZLo";
            default: return "ZHi";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [16:0] c, input logic [31:0] md);
        dp_if.PCout   = c[0];
        dp_if.Zlowout = c[1];
        dp_if.MDRout  = c[2];
        dp_if.R2out   = c[3];
        dp_if.R3out   = c[4];
        dp_if.MARin   = c[5];
        dp_if.Zin     = c[6];
        dp_if.PCin    = c[7];
        dp_if.MDRin   = c[8];
        dp_if.Yin     = c[9];
        dp_if.IRin    = c[10];
        dp_if.R1in    = c[11];
        dp_if.R2in    = c[12];
        dp_if.R3in    = c[13];
        dp_if.IncPC   = c[14];
        dp_if.AND     = c[15];
        dp_if.Read    = c[16];
        dp_if.Mdatain = md;
    endtask

    task automatic check_all_zero(input string tag);
        for (int r = R_R1; r <= R_ZHI; r++) begin
            check($sformatf("%s_%s", tag, reg_name(r)), get_reg(r), 32'h0);
        end
    endtask

    // Called at a falling edge: apply controls, check the bus, clock, check registers.
    task automatic run_vec(input int idx, input vec_t v);
        drive(v.ctrl, v.md);
        #1;
        if (v.chk_bus) check($sformatf("v%0d_bus", idx), dp_if.BusMuxOut, v.exp_bus);
        @(posedge Clock);
        #1;
        if (v.sel_a != R_NONE) check($sformatf("v%0d_%s", idx, reg_name(v.sel_a)), get_reg(v.sel_a), v.exp_a);
        if (v.sel_b != R_NONE) check($sformatf("v%0d_%s", idx, reg_name(v.sel_b)), get_reg(v.sel_b), v.exp_b);
        $display("vec %0d ctrl=%05h md=%08h bus=%08h", idx, v.ctrl, v.md, dp_if.BusMuxOut);
        @(negedge Clock);
    endtask

    initial begin
        // Register loads from memory via MDR
        vecs[0]  = '{C_READ | C_MDRIN,             32'h34,       0, 32'h0,        R_MDR, 32'h34,       R_NONE, 32'h0};
        vecs[1]  = '{C_MDROUT | C_R2IN,            32'h0,        1, 32'h34,       R_R2,  32'h34,       R_NONE, 32'h0};
        vecs[2]  = '{C_READ | C_MDRIN,             32'h14,       0, 32'h0,        R_MDR, 32'h14,       R_NONE, 32'h0};
        vecs[3]  = '{C_MDROUT | C_R3IN,            32'h0,        1, 32'h14,       R_R3,  32'h14,       R_NONE, 32'h0};
        // AND instruction
        vecs[4]  = '{C_R2OUT | C_YIN,              32'h0,        1, 32'h34,       R_Y,   32'h34,       R_NONE, 32'h0};
        vecs[5]  = '{C_R3OUT | C_AND | C_ZIN,      32'h0,        1, 32'h14,       R_ZLO, 32'h14,       R_ZHI,  32'h0};
        vecs[6]  = '{C_ZLOWOUT | C_R1IN,           32'h0,        1, 32'h14,       R_R1,  32'h14,       R_NONE, 32'h0};
        // Fetch with PC = 5
        vecs[7]  = '{C_READ | C_MDRIN,             32'h5,        0, 32'h0,        R_MDR, 32'h5,        R_NONE, 32'h0};
        vecs[8]  = '{C_MDROUT | C_PCIN,            32'h0,        1, 32'h5,        R_PC,  32'h5,        R_NONE, 32'h0};
        vecs[9]  = '{C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 32'h0, 1, 32'h5,        R_MAR, 32'h5,        R_ZLO,  32'h6};
        vecs[10] = '{C_ZLOWOUT | C_PCIN | C_READ | C_MDRIN, 32'h28918000, 1, 32'h6, R_PC, 32'h6,       R_MDR,  32'h28918000};
        vecs[11] = '{C_MDROUT | C_IRIN,            32'h0,        1, 32'h28918000, R_IR,  32'h28918000, R_NONE, 32'h0};
        // IncPC wrap
        vecs[12] = '{C_READ | C_MDRIN,             32'hFFFFFFFF, 0, 32'h0,        R_MDR, 32'hFFFFFFFF, R_NONE, 32'h0};
        vecs[13] = '{C_MDROUT | C_PCIN,            32'h0,        1, 32'hFFFFFFFF, R_PC,  32'hFFFFFFFF, R_NONE, 32'h0};
        vecs[14] = '{C_PCOUT | C_INCPC | C_ZIN,    32'h0,        1, 32'hFFFFFFFF, R_ZLO, 32'h0,        R_ZHI,  32'h0};
        // Default add: Y + bus, wrapping
        vecs[15] = '{C_PCOUT | C_YIN,              32'h0,        1, 32'hFFFFFFFF, R_Y,   32'hFFFFFFFF, R_NONE, 32'h0};
        vecs[16] = '{C_R3OUT | C_ZIN,              32'h0,        1, 32'h14,       R_ZLO, 32'h13,       R_ZHI,  32'h0};
        // Same register as source and destination keeps its pre-edge value
        vecs[17] = '{C_R2OUT | C_R2IN,             32'h0,        1, 32'h34,       R_R2,  32'h34,       R_NONE, 32'h0};
        // Idle bus; enables low hold; MDR from bus when Read low
        vecs[18] = '{17'h0,                        32'hDEADBEEF, 1, 32'h0,        R_R1,  32'h14,       R_MDR,  32'hFFFFFFFF};
        vecs[19] = '{C_R3OUT | C_MDRIN,            32'hDEADBEEF, 1, 32'h14,       R_MDR, 32'h14,       R_NONE, 32'h0};
        // Bus priority
        vecs[20] = '{C_MDROUT | C_R2OUT,           32'h0,        1, 32'h14,       R_R2,  32'h34,       R_NONE, 32'h0};
        vecs[21] = '{C_ZLOWOUT | C_MDROUT | C_PCOUT, 32'h0,      1, 32'h13,       R_NONE, 32'h0,       R_NONE, 32'h0};
        vecs[22] = '{C_PCOUT | C_R2OUT | C_R3OUT,  32'h0,        1, 32'hFFFFFFFF, R_NONE, 32'h0,       R_NONE, 32'h0};
        vecs[23] = '{C_R2OUT | C_R3OUT,            32'h0,        1, 32'h34,       R_NONE, 32'h0,       R_NONE, 32'h0};
        // AND wins over IncPC: Y = FFFFFFFF, bus = R3 = 0x14
        vecs[24] = '{C_R3OUT | C_AND | C_INCPC | C_ZIN, 32'h0,   1, 32'h14,       R_ZLO, 32'h14,       R_NONE, 32'h0};

        Clear = 1'b1;
        drive(17'h0, 32'h0);
        @(posedge Clock);
        #1;
        check_all_zero("reset");
        @(negedge Clock);
        Clear = 1'b0;

        // Load R1 = 0x18, then Clear must wipe it
        begin
            vec_t v;
            v = '{C_READ | C_MDRIN, 32'h18, 0, 32'h0, R_MDR, 32'h18, R_NONE, 32'h0};
            run_vec(100, v);
            v = '{C_MDROUT | C_R1IN, 32'h0, 1, 32'h18, R_R1, 32'h18, R_NONE, 32'h0};
            run_vec(101, v);
        end
        Clear = 1'b1;
        drive(C_MDROUT | C_R2IN | C_YIN, 32'h0);
        @(posedge Clock);
        #1;
        check_all_zero("clear");
        $display("clear pulse after R1 load");
        @(negedge Clock);
        Clear = 1'b0;

        for (int i = 0; i < N_VEC; i++) begin
            run_vec(i, vecs[i]);
        end

        // Clear mid-fetch overrides every enable and aborts the sequence
        Clear = 1'b1;
        drive(C_PCOUT | C_MARIN | C_INCPC | C_ZIN | C_READ | C_MDRIN | C_R1IN, 32'hA5A5A5A5);
        @(posedge Clock);
        #1;
        check_all_zero("midclr");
        $display("clear mid-sequence");
        @(negedge Clock);
        Clear = 1'b0;
        drive(C_ZLOWOUT | C_PCIN, 32'h0);
        #1;
        check("midclr_bus", dp_if.BusMuxOut, 32'h0);
        @(posedge Clock);
        #1;
        check("midclr_pc", dp_if.PC_q, 32'h0);
        @(negedge Clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_path.md
DATA_PATH -- requirements
Module: data_path

Interface
REQ-001 Clock  in  1  sole clock; all state updates on rising edge.
REQ-002 Clear  in  1  reset, synchronous, active-high.
REQ-003 PCout, Zlowout, MDRout, R2out, R3out  in  1 each  bus-source selects.
REQ-004 MARin, Zin, PCin, MDRin, Yin, IRin, R1in, R2in, R3in  in  1 each  register load enables.
REQ-005 IncPC  in  1  ALU op: Z = bus + 1.
REQ-006 AND  in  1  ALU op: Z = Y & bus.
REQ-007 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-008 Mdatain  in  32  memory read data.
REQ-009 BusMuxOut  out  32  current internal bus value.
REQ-010 R1_q, R2_q, R3_q, PC_q, MAR_q, IR_q, MDR_q, Y_q, ZLo_q, ZHi_q  out  32 each  register contents for observation.

Function
REQ-011 The bus SHALL be combinational, one source per cycle.
  - Priority when several selects are high: Zlowout > MDRout > PCout > R2out > R3out.
  - With no select high, the bus SHALL be 0x00000000.
REQ-012 Registers R1, R2, R3, PC, MAR, IR and Y SHALL each load BusMuxOut on the rising edge when their enable is high, and hold otherwise.
REQ-013 MDR SHALL load (Read ? Mdatain : BusMuxOut) on the rising edge when MDRin is high, and hold otherwise.
REQ-014 The ALU SHALL be combinational with operand A = Y and operand B = bus.
  - AND high: result = Y & bus.
  - IncPC high and AND low: result = bus + 1, wrapping modulo 2^32 (0xFFFFFFFF -> 0x00000000).
  - Neither high: result = Y + bus, modulo 2^32.
REQ-015 The Z register is 64 bits; when Zin is high on a rising edge, ZLo SHALL take the 32-bit ALU result and ZHi SHALL take 0x00000000.
REQ-016 Load latency SHALL be one clock edge.
  - A value loaded at edge N is visible on the bus from edge N onward.
  - Register-to-register transfer through Z takes two edges: Zin, then Zlowout + destination enable.
REQ-017 Simultaneous source and destination on the same register (e.g. PCout with PCin) SHALL load the pre-edge value; no combinational loop is allowed.
REQ-018 Enables sampled low SHALL cause no change; glitches between edges SHALL have no effect.

Reset
REQ-019 When Clear is high at a rising edge, all registers SHALL become 0x00000000, and Clear SHALL override every load enable.
REQ-020 A Clear asserted mid-sequence SHALL abort the sequence; state after that edge SHALL equal the reset state.

Structure
REQ-021 A shared package SHALL hold the data-width constant (32) and the Z width (64).
REQ-022 One sub-module, register32, SHALL be used for every 32-bit register. It is a 32-bit D register with load enable and synchronous clear. Z is built from two instances of it.
REQ-023 The bus multiplexer, MDR input mux and ALU SHALL be combinational logic inside data_path.

Verification
REQ-024 Reset: load R1 = 0x18, then pulse Clear -> every register output reads 0x00000000 after the edge.
REQ-025 Register load: Read = 1, MDRin = 1, Mdatain = 0x00000034; next cycle MDRout = 1, R2in = 1 -> R2_q = 0x34. Repeat with 0x14 into R3 -> R3_q = 0x14.
REQ-026 AND instruction, with R2 = 0x34 and R3 = 0x14:
  - Cycle 1: R2out, Yin.
  - Cycle 2: R3out, AND, Zin -> ZLo_q = 0x14.
  - Cycle 3: Zlowout, R1in -> R1_q = 0x00000014.
REQ-027 Fetch with PC = 0x00000005:
  - T0: PCout, MARin, IncPC, Zin -> MAR_q = 5, ZLo_q = 6.
  - T1: Zlowout, PCin, Read, MDRin, Mdatain = 0x28918000 -> PC_q = 6, MDR_q = 0x28918000.
  - T2: MDRout, IRin -> IR_q = 0x28918000.
REQ-028 Wrap: PC = 0xFFFFFFFF, then PCout, IncPC, Zin -> ZLo_q = 0x00000000 and ZHi_q = 0.
REQ-029 Bus priority/idle: no select high -> BusMuxOut = 0; MDRout and R2out high together -> BusMuxOut = MDR_q.
